alu_md: RTL and testbench

- Parametrised-width successor of the single-cycle execute ALU.
- Same op encoding for single-cycle ops, plus an iterative multiply/divide unit with HI/LO registers.
- CLO/CLZ are width-generic and correct for all-ones and all-zero inputs.
- Sits in the EX stage; a valid/ready handshake stalls issue while a multi-cycle op runs.

---
 rtl/alu_pkg.sv | 58 +++++
 rtl/alu_muldiv.sv | 133 +++++++++++++
 rtl/alu_md.sv | 100 ++++++++++
 tb/tb_alu_md.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage ALU: op codes, mul/div FSM states and
// a width-generic leading-zero counter.
package alu_pkg;

    // Single-cycle op codes
    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_ADDU  = 5'd1;
    localparam logic [4:0] OP_SUB   = 5'd3;
    localparam logic [4:0] OP_AND   = 5'd4;
    localparam logic [4:0] OP_OR    = 5'd5;
    localparam logic [4:0] OP_XOR   = 5'd6;
    localparam logic [4:0] OP_NOR   = 5'd7;
    localparam logic [4:0] OP_ADDI  = 5'd8;
    localparam logic [4:0] OP_ADDIU = 5'd9;
    localparam logic [4:0] OP_LT    = 5'd10;
    localparam logic [4:0] OP_LTU   = 5'd11;
    localparam logic [4:0] OP_ANDI  = 5'd12;
    localparam logic [4:0] OP_ORI   = 5'd13;
    localparam logic [4:0] OP_XORI  = 5'd14;
    localparam logic [4:0] OP_LU    = 5'd15;
    localparam logic [4:0] OP_LTZ   = 5'd17;
    localparam logic [4:0] OP_EQ    = 5'd20;
    localparam logic [4:0] OP_NE    = 5'd21;
    localparam logic [4:0] OP_LEZ   = 5'd22;
    localparam logic [4:0] OP_GTZ   = 5'd23;
    localparam logic [4:0] OP_GEZ   = 5'd25;
    localparam logic [4:0] OP_CLO   = 5'd28;
    localparam logic [4:0] OP_CLZ   = 5'd29;
    localparam logic [4:0] OP_MFHI  = 5'd30;
    localparam logic [4:0] OP_MFLO  = 5'd31;

    // Multi-cycle op codes
    localparam logic [4:0] OP_MULT  = 5'd16;
    localparam logic [4:0] OP_MULTU = 5'd18;
    localparam logic [4:0] OP_DIV   = 5'd24;
    localparam logic [4:0] OP_DIVU  = 5'd26;

    typedef enum logic [1:0] {IDLE, RUN, FIX} md_state_t;

    // Leading zeros of a 64-bit word (0..64) by binary halving. Narrower
    // operands are left-aligned by the caller and padded below with ones,
    // so the count saturates at the operand width.
    function automatic logic [6:0] lead_zeros64(input logic [63:0] x);
        logic [63:0] v;
        logic [6:0]  n;
        v = x;
        n = 7'd0;
        if (v == 64'd0) return 7'd64;
        if (v[63:32] == 32'd0) begin n = n + 7'd32; v = v << 32; end
        if (v[63:48] == 16'd0) begin n = n + 7'd16; v = v << 16; end
        if (v[63:56] == 8'd0)  begin n = n + 7'd8;  v = v << 8;  end
        if (v[63:60] == 4'd0)  begin n = n + 7'd4;  v = v << 4;  end
        if (v[63:62] == 2'd0)  begin n = n + 7'd2;  v = v << 2;  end
        if (v[63] == 1'b0)     begin n = n + 7'd1;               end
        return n;
    endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers. One step per
// clock: shift-add multiply, restoring divide; signs are applied in FIX.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         is_div,
    input  logic         is_signed,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         idle,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] res_lo,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    localparam int CNTW = $clog2(W);
    localparam logic [CNTW-1:0] LAST = CNTW'(W - 1);

    md_state_t       state, state_nx;
    logic [CNTW-1:0] cnt;

    // Iteration datapath: acc is partial product high half / remainder,
    // mq is multiplier / dividend shifting into quotient, d is the other operand.
    logic [W-1:0] acc, mq, d;
    logic         div_r, neg_q, neg_r, div0;

    logic [W-1:0]   a_mag, b_mag;
    logic [W:0]     sum, sh;
    logic [W-1:0]   diff;
    logic           ge;
    logic [2*W-1:0] prod, prod_fix;
    logic [W-1:0]   q_fix, r_fix, hi_fix, lo_fix;

    assign a_mag = (is_signed && a[W-1]) ? -a : a;
    assign b_mag = (is_signed && b[W-1]) ? -b : b;

    // One multiply step: add d when the current multiplier bit is set.
    assign sum  = {1'b0, acc} + (mq[0] ? {1'b0, d} : '0);
    // One restoring-divide step: shift in the next dividend bit, try subtract.
    assign sh   = {acc, mq[W-1]};
    assign ge   = (sh >= {1'b0, d});
    assign diff = sh[W-1:0] - d;

    assign prod     = {acc, mq};
    assign prod_fix = neg_q ? -prod : prod;
    assign q_fix    = div0 ? '1 : (neg_q ? -mq : mq);
    assign r_fix    = neg_r ? -acc : acc;
    assign hi_fix   = div_r ? r_fix : prod_fix[2*W-1:W];
    assign lo_fix   = div_r ? q_fix : prod_fix[W-1:0];

    assign idle   = (state == IDLE);
    assign done   = (state == FIX);
    assign res_lo = lo_fix;

    // Next-state logic: IDLE -> RUN on start, W steps in RUN, one FIX cycle.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves it unassigned and infers a latch.
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (cnt == LAST) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Control state, counter, busy flag and architectural HI/LO.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt  <= '0;
                        busy <= 1'b1;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) busy <= 1'b0;
                end
                FIX: begin
                    hi <= hi_fix;
                    lo <= lo_fix;
                end
                default: ;
            endcase
        end
    end

    // Operand latch and per-step update of the working registers.
    always_ff @(posedge clk) begin
        // NOTE: working registers carry no reset; they are always loaded on start before being read.
        case (state)
            IDLE: begin
                if (start) begin
                    acc   <= '0;
                    mq    <= a_mag;
                    d     <= b_mag;
                    div_r <= is_div;
                    neg_q <= is_signed && (a[W-1] ^ b[W-1]);
                    neg_r <= is_signed && is_div && a[W-1];
                    div0  <= is_div && (b == '0);
                end
            end
            RUN: begin
                if (div_r) begin
                    acc <= ge ? diff : sh[W-1:0];
                    mq  <= {mq[W-2:0], ge};
                end else begin
                    acc <= sum[W:1];
                    mq  <= {sum[0], mq[W-1:1]};
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_md.sv
// EX-stage ALU: single-cycle datapath, registered result, valid/ready
// handshake, and the iterative multiply/divide unit.
module alu_md
    import alu_pkg::*;
#(
    parameter int W  = 32,
    parameter int CW = $clog2(W) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [4:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    output logic [W-1:0] out,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         busy
);

    logic         accept, is_md, md_is_div, md_is_signed;
    logic         md_idle, md_done;
    logic [W-1:0] md_res_lo, alu_res;
    logic [CW-1:0] clz_cnt, clo_cnt;
    logic [63:0]  pad;

    assign is_md        = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    assign md_is_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign md_is_signed = (op == OP_MULT) || (op == OP_DIV);
    assign in_ready     = md_idle;
    assign accept       = in_valid && in_ready;

    // Left-align a in 64 bits and fill below with ones so the count stops at W.
    assign pad     = (64'd1 << (64 - W)) - 64'd1;
    assign clz_cnt = CW'(lead_zeros64((64'(a) << (64 - W)) | pad));
    assign clo_cnt = CW'(lead_zeros64((64'(~a) << (64 - W)) | pad));

    alu_muldiv #(.W(W)) u_muldiv (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (accept && is_md),
        .is_div    (md_is_div),
        .is_signed (md_is_signed),
        .a         (a),
        .b         (b),
        .idle      (md_idle),
        .busy      (busy),
        .done      (md_done),
        .res_lo    (md_res_lo),
        .hi        (hi),
        .lo        (lo)
    );

    // Single-cycle result selection; unlisted and mul/div codes give zero here.
    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD, OP_ADDU, OP_ADDI, OP_ADDIU: alu_res = a + b;
            OP_SUB:           alu_res = a - b;
            OP_AND, OP_ANDI:  alu_res = a & b;
            OP_OR,  OP_ORI:   alu_res = a | b;
            OP_XOR, OP_XORI:  alu_res = a ^ b;
            OP_NOR:           alu_res = ~(a | b);
            OP_LT:            alu_res = W'($signed(a) < $signed(b));
            OP_LTU:           alu_res = W'(a < b);
            OP_LU:            alu_res = {a[W/2-1:0], {(W/2){1'b0}}};
            OP_LTZ:           alu_res = W'(a[W-1]);
            OP_EQ:            alu_res = W'(a == b);
            OP_NE:            alu_res = W'(a != b);
            OP_LEZ:           alu_res = W'(a[W-1] || (a == '0));
            OP_GTZ:           alu_res = W'(!a[W-1] && (a != '0));
            OP_GEZ:           alu_res = W'(!a[W-1]);
            OP_CLO:           alu_res = W'(clo_cnt);
            OP_CLZ:           alu_res = W'(clz_cnt);
            OP_MFHI:          alu_res = hi;
            OP_MFLO:          alu_res = lo;
            default:          alu_res = '0;
        endcase
    end

    // Registered result: single-cycle ops on accept, mul/div on FIX.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (accept && !is_md) begin
                out       <= alu_res;
                out_valid <= 1'b1;
            end else if (md_done) begin
                out       <= md_res_lo;
                out_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_md.sv
// Directed self-checking bench for alu_md at W=32.
module tb_alu_md;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op;
    logic [31:0] a, b;
    logic        out_valid;
    logic [31:0] out, hi, lo;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    alu_md #(.W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out       (out),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present an op and hold it until accepted; returns #1 after the accept edge.
    task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        while (!in_ready && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) check("issue_timeout", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [4:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp);
        issue(o, x, y);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check(tag, 64'(out), 64'(exp));
        @(posedge clk); #1;
        check({tag, "_pulse"}, 64'(out_valid), 64'd0);
    endtask

    task automatic run_md(input string tag, input logic [4:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int lat, nb;
        issue(o, x, y);
        lat = 0;
        nb  = 0;
        while (!out_valid && lat < 200) begin
            if (busy) nb++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"},   64'(lat), 64'd33);
        check({tag, "_busy"},  64'(nb), 64'd32);
        check({tag, "_out"},   64'(out), 64'(exp_lo));
        check({tag, "_hi"},    64'(hi), 64'(exp_hi));
        check({tag, "_lo"},    64'(lo), 64'(exp_lo));
        check({tag, "_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int nr;
        int seen;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        op       = '0;
        a        = '0;
        b        = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out",       64'(out), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy",      64'(busy), 64'd0);
        check("rst_hi",        64'(hi), 64'd0);
        check("rst_lo",        64'(lo), 64'd0);
        check("rst_in_ready",  64'(in_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-cycle ops
        run_op("add",   OP_ADD,   32'd5,        32'd7,        32'd12);
        run_op("addiu", OP_ADDIU, 32'hFFFFFFFF, 32'd1,        32'd0);
        run_op("sub",   OP_SUB,   32'd3,        32'd5,        32'hFFFFFFFE);
        run_op("and",   OP_AND,   32'hF0F0FF00, 32'h0FF0F0F0, 32'h00F0F000);
        run_op("or",    OP_ORI,   32'hF0000000, 32'h0000000F, 32'hF000000F);
        run_op("xor",   OP_XOR,   32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00);
        run_op("nor",   OP_NOR,   32'd0,        32'd0,        32'hFFFFFFFF);
        run_op("lt",    OP_LT,    32'hFFFFFFFF, 32'd1,        32'd1);
        run_op("ltu",   OP_LTU,   32'hFFFFFFFF, 32'd1,        32'd0);
        run_op("lu",    OP_LU,    32'h1234ABCD, 32'd0,        32'hABCD0000);
        run_op("ltz",   OP_LTZ,   32'h80000000, 32'd0,        32'd1);
        run_op("eq",    OP_EQ,    32'd7,        32'd7,        32'd1);
        run_op("ne",    OP_NE,    32'd7,        32'd7,        32'd0);
        run_op("lez0",  OP_LEZ,   32'd0,        32'd0,        32'd1);
        run_op("gtz0",  OP_GTZ,   32'd0,        32'd0,        32'd0);
        run_op("gtz5",  OP_GTZ,   32'd5,        32'd0,        32'd1);
        run_op("gez",   OP_GEZ,   32'h80000000, 32'd0,        32'd0);

        // Multiply / divide
        run_md("mult",  OP_MULT,  32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run_op("unl19", 5'd19,    32'd9,        32'd9,        32'd0);
        check("unl19_hi", 64'(hi), 64'hFFFFFFFF);
        check("unl19_lo", 64'(lo), 64'hFFFFFFEB);
        run_md("div",   OP_DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_md("divu",  OP_DIVU,  32'hFFFFFFF9, 32'd2, 32'h00000001, 32'h7FFFFFFC);
        run_md("div0",  OP_DIV,   32'd5,        32'd0, 32'h00000005, 32'hFFFFFFFF);
        run_md("divmin",OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

        // Leading counts
        run_op("clz0",  OP_CLZ,   32'd0,        32'd0, 32'd32);
        run_op("clo1s", OP_CLO,   32'hFFFFFFFF, 32'd0, 32'd32);
        run_op("clo4",  OP_CLO,   32'hF0000000, 32'd0, 32'd4);
        run_op("clz1",  OP_CLZ,   32'd1,        32'd0, 32'd31);

        // Back-pressure: ADD held behind MULTU
        in_valid = 1'b1;
        op = OP_MULTU; a = 32'd3; b = 32'd5;
        @(posedge clk); #1;
        op = OP_ADD; a = 32'd1; b = 32'd2;
        nr = 0;
        while (!in_ready && nr < 200) begin
            nr++;
            @(posedge clk); #1;
        end
        check("bp_stall",     64'(nr), 64'd33);
        check("bp_mul_valid", 64'(out_valid), 64'd1);
        check("bp_mul_out",   64'(out), 64'd15);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_add_valid", 64'(out_valid), 64'd1);
        check("bp_add_out",   64'(out), 64'd3);
        run_op("mflo", OP_MFLO, 32'd0, 32'd0, 32'd15);
        run_op("mfhi", OP_MFHI, 32'd0, 32'd0, 32'd0);

        // Reset while a divide is running
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (9) begin
            @(posedge clk); #1;
        end
        check("rr_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rr_hi",        64'(hi), 64'd0);
        check("rr_lo",        64'(lo), 64'd0);
        check("rr_busy",      64'(busy), 64'd0);
        check("rr_in_ready",  64'(in_ready), 64'd1);
        check("rr_out_valid", 64'(out_valid), 64'd0);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("rr_no_pulse", 64'(seen), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
